// File: rtl/mtx_cp_initiator_pkg.sv
// Shared types and constants for the matrix CP initiator.
package mtx_pkg;

   // Widest address/data the stored command can carry; top parameters must not exceed these.
   localparam int MTX_CP_ADDR_W = 32;
   localparam int MTX_CP_DATA_W = 32;

   // Read data returned with an aborted (timed-out) transaction.
   localparam logic [31:0] MTX_CP_TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef struct packed {
      logic                     wr;
      logic [MTX_CP_ADDR_W-1:0] addr;
      logic [MTX_CP_DATA_W-1:0] wdata;
   } mtx_cp_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RSP
   } mtx_cp_init_state_e;

endpackage

// File: rtl/mtx_cp_initiator_if.sv
// Host command/response channel plus CP request port of the initiator.
// master: the initiator block itself; slave: host + CP responder side.
interface mtx_cp_initiator_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  i_cmd_vld;
   logic                  o_cmd_rdy;
   logic                  i_cmd_wr;
   logic [ADDR_WIDTH-1:0] i_cmd_addr;
   logic [DATA_WIDTH-1:0] i_cmd_wdata;
   logic                  o_rsp_vld;
   logic                  i_rsp_rdy;
   logic [DATA_WIDTH-1:0] o_rsp_rdata;
   logic                  o_rsp_err;
   logic                  o_cp_vld;
   logic                  o_cp_wr;
   logic [ADDR_WIDTH-1:0] o_cp_addr;
   logic [DATA_WIDTH-1:0] o_cp_wdata;
   logic                  i_cp_rdy;
   logic [DATA_WIDTH-1:0] i_cp_rdata;

   modport master (
      input  i_cmd_vld, i_cmd_wr, i_cmd_addr, i_cmd_wdata, i_rsp_rdy, i_cp_rdy, i_cp_rdata,
      output o_cmd_rdy, o_rsp_vld, o_rsp_rdata, o_rsp_err, o_cp_vld, o_cp_wr, o_cp_addr, o_cp_wdata
   );

   modport slave (
      output i_cmd_vld, i_cmd_wr, i_cmd_addr, i_cmd_wdata, i_rsp_rdy, i_cp_rdy, i_cp_rdata,
      input  o_cmd_rdy, o_rsp_vld, o_rsp_rdata, o_rsp_err, o_cp_vld, o_cp_wr, o_cp_addr, o_cp_wdata
   );

endinterface

// File: rtl/mtx_cp_initiator_wdog.sv
// mtx_cp_wdog: saturating wait counter for the CP request timeout.
// expired_o flags the cycle in which one more unanswered cycle reaches LIMIT,
// so the request is visible for exactly LIMIT cycles before the abort.
module mtx_cp_wdog #(
   parameter int LIMIT = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);
   localparam logic [W-1:0] MAX  = W'(LIMIT);

   logic [W-1:0] cnt_q, cnt_d;

   // Clear has priority; count only while enabled and never wrap past LIMIT.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != MAX))
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/mtx_cp_initiator.sv
// mtx_cp_initiator: one CP transaction per host command, completion on the
// response channel. Optional request timeout under MTX_CP_INITIATOR_TIMEOUT_EN.
module mtx_cp_initiator
   import mtx_pkg::*;
#(
   parameter int ADDR_WIDTH     = MTX_CP_ADDR_W,
   parameter int DATA_WIDTH     = MTX_CP_DATA_W,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic                sys_clk,
   input logic                sys_rst,
   mtx_cp_initiator_if.master bus
);

   mtx_cp_init_state_e    state_q, state_d;
   mtx_cp_cmd_t           cmd_q, cmd_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef MTX_CP_INITIATOR_TIMEOUT_EN
   logic err_q, err_d;
   logic wd_expired;

   // Counter is held clear outside REQ, so it starts at zero on every entry.
   mtx_cp_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .clr_i     (state_q != REQ),
      .en_i      ((state_q == REQ) && !bus.i_cp_rdy),
      .expired_o (wd_expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Next-state and datapath capture; ack beats timeout in the same cycle.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      rdata_d = rdata_q;
`ifdef MTX_CP_INITIATOR_TIMEOUT_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: if (bus.i_cmd_vld) begin
            cmd_d.wr    = bus.i_cmd_wr;
            cmd_d.addr  = MTX_CP_ADDR_W'(bus.i_cmd_addr);
            cmd_d.wdata = MTX_CP_DATA_W'(bus.i_cmd_wdata);
            state_d     = REQ;
         end
         REQ: if (bus.i_cp_rdy) begin
            rdata_d = cmd_q.wr ? '0 : bus.i_cp_rdata;
`ifdef MTX_CP_INITIATOR_TIMEOUT_EN
            err_d   = 1'b0;
`endif
            state_d = RSP;
         end
`ifdef MTX_CP_INITIATOR_TIMEOUT_EN
         else if (wd_expired) begin
            rdata_d = DATA_WIDTH'(MTX_CP_TIMEOUT_RDATA);
            err_d   = 1'b1;
            state_d = RSP;
         end
`endif
         RSP: if (bus.i_rsp_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and captured fields; reset abandons any in-flight transaction.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         rdata_q <= '0;
`ifdef MTX_CP_INITIATOR_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         rdata_q <= rdata_d;
`ifdef MTX_CP_INITIATOR_TIMEOUT_EN
         err_q   <= err_d;
`endif
      end
   end

   assign bus.o_cmd_rdy   = (state_q == IDLE);
   assign bus.o_cp_vld    = (state_q == REQ);
   assign bus.o_cp_wr     = cmd_q.wr;
   assign bus.o_cp_addr   = ADDR_WIDTH'(cmd_q.addr);
   assign bus.o_cp_wdata  = DATA_WIDTH'(cmd_q.wdata);
   assign bus.o_rsp_vld   = (state_q == RSP);
   assign bus.o_rsp_rdata = rdata_q;
`ifdef MTX_CP_INITIATOR_TIMEOUT_EN
   assign bus.o_rsp_err   = err_q;
`else
   assign bus.o_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mtx_cp_initiator.sv
// Self-checking bench for mtx_cp_initiator. Timeout scenarios run only when
// MTX_CP_INITIATOR_TIMEOUT_EN is defined.
module tb_mtx_cp_initiator;
   import mtx_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   int   checks  = 0;
   int   errors  = 0;

   mtx_cp_cmd_t exp_cp[$];
   rsp_t        exp_rsp[$];

   mtx_cp_initiator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mtx_cp_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   // One clock: score handshakes just before the edge, return 1 unit after it.
   task automatic tick();
      mtx_cp_cmd_t act_c, exp_c;
      rsp_t        act_r, exp_r;
      @(negedge sys_clk);
      if (bus.o_cp_vld && bus.i_cp_rdy) begin
         act_c = {bus.o_cp_wr, bus.o_cp_addr, bus.o_cp_wdata};
         checks++;
         if (exp_cp.size() == 0) begin
            errors++; $display("FAIL cp_xfer unexpected: got %h required none", act_c);
         end else begin
            exp_c = exp_cp.pop_front();
            if (act_c !== exp_c) begin errors++; $display("FAIL cp_xfer: got %h required %h", act_c, exp_c); end
         end
      end
      if (bus.o_rsp_vld && bus.i_rsp_rdy) begin
         act_r = {bus.o_rsp_rdata, bus.o_rsp_err};
         checks++;
         if (exp_rsp.size() == 0) begin
            errors++; $display("FAIL rsp unexpected: got %h required none", act_r);
         end else begin
            exp_r = exp_rsp.pop_front();
            if (act_r !== exp_r) begin errors++; $display("FAIL rsp: got %h required %h", act_r, exp_r); end
         end
      end
      @(posedge sys_clk); #1;
   endtask

   task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      bus.i_cmd_vld   = 1'b1;
      bus.i_cmd_wr    = wr;
      bus.i_cmd_addr  = addr;
      bus.i_cmd_wdata = wdata;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge sys_clk);
      #1;
      checks++;
      if ({bus.o_cmd_rdy, bus.o_cp_vld, bus.o_cp_wr, bus.o_rsp_vld, bus.o_rsp_err} !== 5'b10000) begin
         errors++; $display("FAIL reset_ctrl got %b required 10000",
            {bus.o_cmd_rdy, bus.o_cp_vld, bus.o_cp_wr, bus.o_rsp_vld, bus.o_rsp_err});
      end
      checks++;
      if ({bus.o_cp_addr, bus.o_cp_wdata, bus.o_rsp_rdata} !== 96'h0) begin
         errors++; $display("FAIL reset_data got %h required 0", {bus.o_cp_addr, bus.o_cp_wdata, bus.o_rsp_rdata});
      end
      sys_rst = 1'b0;
      tick();
      checks++;
      if (bus.o_cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_idle cmd_rdy got %b required 1", bus.o_cmd_rdy); end
   endtask

   task automatic test_write();
      bus.i_cp_rdy = 1'b1; bus.i_rsp_rdy = 1'b1; bus.i_cp_rdata = 32'hFFFF_FFFF;
      drive_cmd(1'b1, 32'h10, 32'hA5A5_0001);
      exp_cp.push_back(mtx_cp_cmd_t'({1'b1, 32'h10, 32'hA5A5_0001}));
      exp_rsp.push_back(rsp_t'({32'h0, 1'b0}));
      tick();
      bus.i_cmd_vld = 1'b0;
      checks++;
      if ({bus.o_cp_vld, bus.o_cp_wr, bus.o_cmd_rdy} !== 3'b110) begin
         errors++; $display("FAIL wr_req vld/wr/cmd_rdy got %b required 110", {bus.o_cp_vld, bus.o_cp_wr, bus.o_cmd_rdy});
      end
      tick();
      checks++;
      if ({bus.o_rsp_vld, bus.o_cp_vld} !== 2'b10) begin
         errors++; $display("FAIL wr_rsp rsp_vld/cp_vld got %b required 10", {bus.o_rsp_vld, bus.o_cp_vld});
      end
      tick();
      checks++;
      if ({bus.o_cmd_rdy, bus.o_rsp_vld} !== 2'b10) begin
         errors++; $display("FAIL wr_done cmd_rdy/rsp_vld got %b required 10", {bus.o_cmd_rdy, bus.o_rsp_vld});
      end
   endtask

   task automatic test_read_wait();
      bus.i_cp_rdy = 1'b0; bus.i_rsp_rdy = 1'b1; bus.i_cp_rdata = 32'h0;
      drive_cmd(1'b0, 32'h24, 32'h7777_7777);
      exp_cp.push_back(mtx_cp_cmd_t'({1'b0, 32'h24, 32'h7777_7777}));
      exp_rsp.push_back(rsp_t'({32'h1234_5678, 1'b0}));
      tick();
      drive_cmd(1'b1, 32'hFFFF_0000, 32'h0BAD_0BAD);
      bus.i_cmd_vld = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.o_cp_vld, bus.o_cp_wr, bus.o_cp_addr, bus.o_cp_wdata} !== {2'b10, 32'h24, 32'h7777_7777}) begin
            errors++; $display("FAIL rd_stable cyc %0d got %h required %h", i,
               {bus.o_cp_vld, bus.o_cp_wr, bus.o_cp_addr, bus.o_cp_wdata}, {2'b10, 32'h24, 32'h7777_7777});
         end
         tick();
      end
      bus.i_cp_rdy = 1'b1; bus.i_cp_rdata = 32'h1234_5678;
      tick();
      bus.i_cp_rdy = 1'b0; bus.i_cp_rdata = 32'h0;
      checks++;
      if ({bus.o_rsp_vld, bus.o_rsp_rdata} !== {1'b1, 32'h1234_5678}) begin
         errors++; $display("FAIL rd_rsp got %h required %h", {bus.o_rsp_vld, bus.o_rsp_rdata}, {1'b1, 32'h1234_5678});
      end
      tick();
   endtask

   task automatic test_backpressure();
      bus.i_cp_rdy = 1'b1; bus.i_rsp_rdy = 1'b0; bus.i_cp_rdata = 32'hCAFE_0030;
      drive_cmd(1'b0, 32'h30, 32'h0);
      exp_cp.push_back(mtx_cp_cmd_t'({1'b0, 32'h30, 32'h0}));
      exp_rsp.push_back(rsp_t'({32'hCAFE_0030, 1'b0}));
      tick();
      drive_cmd(1'b0, 32'h34, 32'h0);
      tick();
      bus.i_cp_rdata = 32'h0BAD_F00D;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.o_rsp_vld, bus.o_rsp_rdata, bus.o_cmd_rdy, bus.o_cp_vld} !== {1'b1, 32'hCAFE_0030, 2'b00}) begin
            errors++; $display("FAIL bp_hold cyc %0d got %h required %h", i,
               {bus.o_rsp_vld, bus.o_rsp_rdata, bus.o_cmd_rdy, bus.o_cp_vld}, {1'b1, 32'hCAFE_0030, 2'b00});
         end
         tick();
      end
      exp_cp.push_back(mtx_cp_cmd_t'({1'b0, 32'h34, 32'h0}));
      exp_rsp.push_back(rsp_t'({32'h0BAD_F00D, 1'b0}));
      bus.i_rsp_rdy = 1'b1;
      checks++;
      if (bus.o_cmd_rdy !== 1'b0) begin errors++; $display("FAIL bp_hs_cycle cmd_rdy got %b required 0", bus.o_cmd_rdy); end
      tick();
      checks++;
      if (bus.o_cmd_rdy !== 1'b1) begin errors++; $display("FAIL bp_after cmd_rdy got %b required 1", bus.o_cmd_rdy); end
      tick();
      bus.i_cmd_vld = 1'b0;
      checks++;
      if ({bus.o_cp_vld, bus.o_cp_addr} !== {1'b1, 32'h34}) begin
         errors++; $display("FAIL bp_second got %h required %h", {bus.o_cp_vld, bus.o_cp_addr}, {1'b1, 32'h34});
      end
      tick();
      tick();
   endtask

`ifdef MTX_CP_INITIATOR_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      bus.i_cp_rdy = 1'b0; bus.i_rsp_rdy = 1'b1;
      drive_cmd(1'b0, 32'h40, 32'h0);
      exp_rsp.push_back(rsp_t'({32'hDEAD_BEEF, 1'b1}));
      tick();
      bus.i_cmd_vld = 1'b0;
      n = 0;
      while (bus.o_cp_vld === 1'b1 && n < 20) begin n++; tick(); end
      checks++;
      if (n != 8) begin errors++; $display("FAIL to_vld_cycles got %0d required 8", n); end
      checks++;
      if ({bus.o_rsp_vld, bus.o_rsp_err, bus.o_rsp_rdata} !== {2'b11, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL to_rsp got %h required %h", {bus.o_rsp_vld, bus.o_rsp_err, bus.o_rsp_rdata}, {2'b11, 32'hDEAD_BEEF});
      end
      tick();
      drive_cmd(1'b0, 32'h44, 32'h0);
      exp_cp.push_back(mtx_cp_cmd_t'({1'b0, 32'h44, 32'h0}));
      exp_rsp.push_back(rsp_t'({32'h5555_AAAA, 1'b0}));
      tick();
      bus.i_cmd_vld = 1'b0;
      repeat (7) tick();
      checks++;
      if (bus.o_cp_vld !== 1'b1) begin errors++; $display("FAIL to_last_vld got %b required 1", bus.o_cp_vld); end
      bus.i_cp_rdy = 1'b1; bus.i_cp_rdata = 32'h5555_AAAA;
      tick();
      bus.i_cp_rdy = 1'b0;
      checks++;
      if ({bus.o_rsp_vld, bus.o_rsp_err} !== 2'b10) begin
         errors++; $display("FAIL to_last_ack vld/err got %b required 10", {bus.o_rsp_vld, bus.o_rsp_err});
      end
      tick();
   endtask
`endif

   task automatic test_reset_mid();
      bus.i_cp_rdy = 1'b0; bus.i_rsp_rdy = 1'b1;
      drive_cmd(1'b1, 32'h50, 32'h1111_2222);
      tick();
      bus.i_cmd_vld = 1'b0;
      checks++;
      if (bus.o_cp_vld !== 1'b1) begin errors++; $display("FAIL rst_pre cp_vld got %b required 1", bus.o_cp_vld); end
      #2 sys_rst = 1'b1;
      #1;
      checks++;
      if ({bus.o_cp_vld, bus.o_rsp_vld, bus.o_cmd_rdy, bus.o_cp_addr} !== {3'b001, 32'h0}) begin
         errors++; $display("FAIL rst_async got %h required %h", {bus.o_cp_vld, bus.o_rsp_vld, bus.o_cmd_rdy, bus.o_cp_addr}, {3'b001, 32'h0});
      end
      tick();
      sys_rst = 1'b0;
      bus.i_cp_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.o_cmd_rdy, bus.o_cp_vld, bus.o_rsp_vld} !== 3'b100) begin
            errors++; $display("FAIL rst_after cyc %0d got %b required 100", i, {bus.o_cmd_rdy, bus.o_cp_vld, bus.o_rsp_vld});
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int          gap;
      logic        wr;
      logic [31:0] addr, wdata;
      bus.i_cp_rdy = 1'b1; bus.i_rsp_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         gap = 0;
         while (bus.o_cmd_rdy !== 1'b1 && gap < 10) begin gap++; tick(); end
         if (i > 0) begin
            checks++;
            if (gap != 2) begin errors++; $display("FAIL b2b_gap cmd %0d got %0d required 2", i, gap); end
         end
         wr    = 1'(i & 1);
         addr  = 32'h100 + 32'(4 * i);
         wdata = $urandom;
         drive_cmd(wr, addr, wdata);
         bus.i_cp_rdata = ~addr;
         exp_cp.push_back(mtx_cp_cmd_t'({wr, addr, wdata}));
         exp_rsp.push_back(rsp_t'({(wr ? 32'h0 : ~addr), 1'b0}));
         tick();
         bus.i_cmd_vld = 1'b0;
      end
      repeat (3) tick();
      checks++;
      if (exp_cp.size() != 0 || exp_rsp.size() != 0) begin
         errors++; $display("FAIL drain pending cp %0d rsp %0d required 0 0", exp_cp.size(), exp_rsp.size());
      end
   endtask

   initial begin
      bus.i_cmd_vld = 1'b0; bus.i_cmd_wr = 1'b0; bus.i_cmd_addr = '0; bus.i_cmd_wdata = '0;
      bus.i_rsp_rdy = 1'b0; bus.i_cp_rdy = 1'b0; bus.i_cp_rdata = '0;
      test_reset();
      test_write();
      test_read_wait();
      test_backpressure();
`ifdef MTX_CP_INITIATOR_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
